// File: rtl/c7bicu.sv
// c7bicu: direct-mapped, read-only instruction cache of 8-byte fetch granules.
// Hits return one cycle after ack; misses refill through a single-outstanding BIU read.
module c7bicu #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:0] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2,
  input  logic        exu_icu_inv,
  output logic        icu_biu_req,
  output logic [31:0] icu_biu_addr,
  input  logic        biu_icu_ack,
  input  logic        biu_icu_data_valid,
  input  logic [63:0] biu_icu_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 29 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag [LINES];
  logic [63:0]       r_data [LINES];
  logic              r_ic2_vld;
  logic [28:0]       r_ic2_line;
  logic              r_biu_req;
  logic [31:0]       r_biu_addr;
  logic              r_inv_seen;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_ack;
  logic                  w_fill;
  logic                  w_data_vld;
  logic [63:0]           w_data;
  logic                  w_unused_addr_bits;

  // The ic2 line is held through a refill, so it also addresses the line write.
  assign w_idx  = r_ic2_line[INDEX_BITS-1:0];
  assign w_tag  = r_ic2_line[28:INDEX_BITS];
  assign w_hit  = r_ic2_vld & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = r_ic2_vld & ~w_hit;

  assign w_unused_addr_bits = ^ifu_icu_addr_ic1[2:0];

  assign icu_ifu_ack_ic1        = w_ack;
  assign icu_ifu_data_valid_ic2 = w_data_vld;
  assign icu_ifu_data_ic2       = w_data;
  assign icu_biu_req            = r_biu_req;
  assign icu_biu_addr           = r_biu_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_state_nxt = S_MISS_REQ;
        end else begin
          w_state_nxt = S_IDLE;
          w_ack       = ifu_icu_req_ic1 & ~reset;
        end
      end
      S_MISS_REQ: begin
        if (biu_icu_ack) begin
          w_state_nxt = S_MISS_WAIT;
        end else begin
          w_state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_WAIT: begin
        if (biu_icu_data_valid) begin
          w_state_nxt = S_IDLE;
          w_fill      = ~reset;
        end else begin
          w_state_nxt = S_MISS_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Refill data bypasses the array straight to the IFU in its arrival cycle.
  always_comb begin
    w_data_vld = 1'b0;
    w_data     = 64'd0;
    if (reset) begin
      w_data_vld = 1'b0;
      w_data     = 64'd0;
    end else if (w_hit) begin
      w_data_vld = 1'b1;
      w_data     = r_data[w_idx];
    end else if (w_fill) begin
      w_data_vld = 1'b1;
      w_data     = biu_icu_data;
    end else begin
      w_data_vld = 1'b0;
      w_data     = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ic2_vld  <= 1'b0;
      r_ic2_line <= 29'd0;
    end else begin
      r_ic2_vld <= w_ack;
      if (w_ack) begin
        r_ic2_line <= ifu_icu_addr_ic1[31:3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_biu_req  <= 1'b0;
      r_biu_addr <= 32'd0;
    end else if ((r_state == S_IDLE) && w_miss) begin
      r_biu_req  <= 1'b1;
      r_biu_addr <= {r_ic2_line, 3'b000};
    end else if ((r_state == S_MISS_REQ) && biu_icu_ack) begin
      r_biu_req  <= 1'b0;
    end
  end

  // An invalidate during an outstanding refill must keep that line from going valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inv_seen <= 1'b0;
    end else if ((r_state == S_IDLE) && w_miss) begin
      r_inv_seen <= 1'b0;
    end else if (exu_icu_inv && (r_state != S_IDLE)) begin
      r_inv_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || exu_icu_inv) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_fill) begin
      r_valid[w_idx] <= ~r_inv_seen;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= biu_icu_data;
    end
  end

endmodule

// File: tb/tb_c7bicu.sv
// Self-checking bench for c7bicu: directed test-plan scenarios followed by random
// traffic, all compared every cycle against a transaction-level cache model.
module tb_c7bicu;
  localparam int IB = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1;
  logic        icu_ifu_data_valid_ic2;
  logic [63:0] icu_ifu_data_ic2;
  logic        exu_icu_inv;
  logic        icu_biu_req;
  logic [31:0] icu_biu_addr;
  logic        biu_icu_ack;
  logic        biu_icu_data_valid;
  logic [63:0] biu_icu_data;

  always #5 clk = ~clk;

  c7bicu #(.INDEX_BITS(IB)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ifu_icu_req_ic1        (ifu_icu_req_ic1),
    .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .icu_ifu_data_ic2       (icu_ifu_data_ic2),
    .exu_icu_inv            (exu_icu_inv),
    .icu_biu_req            (icu_biu_req),
    .icu_biu_addr           (icu_biu_addr),
    .biu_icu_ack            (biu_icu_ack),
    .biu_icu_data_valid     (biu_icu_data_valid),
    .biu_icu_data           (biu_icu_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: cached line per index (presence = valid), its data, and the refill in flight.
  logic [28:0] m_line [int];
  logic [63:0] m_mem  [int];
  bit          m_ic2_vld  = 1'b0;
  logic [28:0] m_ic2_line = 29'd0;
  int          m_phase    = 0;   // 0: none, 1: request at BIU, 2: awaiting data
  bit          m_poison   = 1'b0;
  bit          m_breq     = 1'b0;
  logic [31:0] m_baddr    = 32'd0;
  logic [28:0] m_fill_line = 29'd0;

  logic        s_ack, s_dv, s_breq;
  logic [63:0] s_data;
  logic [31:0] s_baddr;

  localparam logic [63:0] D0 = 64'h0123456789abcdef;
  localparam logic [63:0] D1 = 64'hfedcba9876543210;
  localparam logic [63:0] D2 = 64'h5a5a00ffc3c31234;
  localparam logic [63:0] D3 = 64'h00000000cafef00d;
  localparam logic [63:0] D4 = 64'hdeaddeaddeaddead;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic cycle(input bit rq, input logic [31:0] ad, input bit iv, input bit rs,
                       input bit ba, input bit bdv, input logic [63:0] bd);
    bit hit, miss, e_ack, fill, e_dv;
    logic [63:0] e_data;
    int ix, fx;
    reset = rs; ifu_icu_req_ic1 = rq; ifu_icu_addr_ic1 = ad; exu_icu_inv = iv;
    biu_icu_ack = ba; biu_icu_data_valid = bdv; biu_icu_data = bd;
    ix    = int'(m_ic2_line[IB-1:0]);
    hit   = m_ic2_vld && m_line.exists(ix) && (m_line[ix] == m_ic2_line);
    miss  = m_ic2_vld && !hit;
    e_ack = rq && !rs && (m_phase == 0) && !miss;
    fill  = !rs && (m_phase == 2) && bdv;
    e_dv  = !rs && (hit || fill);
    e_data = !e_dv ? 64'd0 : (hit ? m_mem[ix] : bd);
    @(negedge clk);
    s_ack = icu_ifu_ack_ic1; s_dv = icu_ifu_data_valid_ic2; s_data = icu_ifu_data_ic2;
    s_breq = icu_biu_req; s_baddr = icu_biu_addr;
    chk("ack", s_ack, e_ack);
    chk("data_valid", s_dv, e_dv);
    chk("data", s_data, e_data);
    chk("biu_req", s_breq, m_breq);
    chk("biu_addr", s_baddr, m_baddr);
    @(posedge clk);
    if (rs) begin
      m_line.delete();
      m_ic2_vld = 1'b0; m_phase = 0; m_breq = 1'b0; m_baddr = 32'd0; m_poison = 1'b0;
    end else begin
      if (fill) begin
        fx = int'(m_fill_line[IB-1:0]);
        m_mem[fx] = bd;
        if (!m_poison) m_line[fx] = m_fill_line;
      end
      if (iv) m_line.delete();
      case (m_phase)
        0: if (miss) begin
             m_phase = 1; m_breq = 1'b1; m_baddr = {m_ic2_line, 3'b000};
             m_fill_line = m_ic2_line; m_poison = 1'b0;
           end
        1: begin
             if (iv) m_poison = 1'b1;
             if (ba) begin m_phase = 2; m_breq = 1'b0; end
           end
        2: begin
             if (iv) m_poison = 1'b1;
             if (bdv) m_phase = 0;
           end
        default: m_phase = 0;
      endcase
      m_ic2_vld = e_ack;
      if (e_ack) m_ic2_line = ad[31:3];
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic run_refill(input logic [63:0] d);
    for (int k = 0; k < 12 && m_phase != 0; k++)
      cycle(1'b0, 32'd0, 1'b0, 1'b0, m_phase == 1, m_phase == 2, d);
  endtask

  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    cycle(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    run_refill(d);
  endtask

  logic [31:0] pool [3] = '{32'h1c000000, 32'h1c000200, 32'h00400000};

  initial begin
    reset = 1'b1; ifu_icu_req_ic1 = 1'b0; ifu_icu_addr_ic1 = 32'd0; exu_icu_inv = 1'b0;
    biu_icu_ack = 1'b0; biu_icu_data_valid = 1'b0; biu_icu_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    cycle(1'b1, 32'h1c000000, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    chk("rst_ack", s_ack, 1'b0);
    chk("rst_biu_req", s_breq, 1'b0);
    chk("rst_biu_addr", s_baddr, 32'd0);
    idle();
    chk("rst_dv", s_dv, 1'b0);

    // Cold miss
    cycle(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("cold_ack", s_ack, 1'b1);
    idle();
    chk("cold_no_dv", s_dv, 1'b0);
    chk("cold_no_ack", s_ack, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk("cold_biu_req", s_breq, 1'b1);
    chk("cold_biu_addr", s_baddr, 32'h1c000000);
    idle();
    idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, D0);
    chk("cold_dv", s_dv, 1'b1);
    chk("cold_data", s_data, D0);
    idle();

    // Rehit
    cycle(1'b1, 32'h1c000004, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("rehit_ack", s_ack, 1'b1);
    idle();
    chk("rehit_dv", s_dv, 1'b1);
    chk("rehit_data", s_data, D0);
    chk("rehit_no_biu_req", s_breq, 1'b0);

    // Back-to-back hits
    preload(32'h1c000008, D1);
    cycle(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("b2b_ack0", s_ack, 1'b1);
    cycle(1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("b2b_ack1", s_ack, 1'b1);
    chk("b2b_data0", s_data, D0);
    idle();
    chk("b2b_dv1", s_dv, 1'b1);
    chk("b2b_data1", s_data, D1);

    // Conflict at index 0
    preload(32'h1c000200, D2);
    cycle(1'b1, 32'h1c000200, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    chk("conf_hit_data", s_data, D2);
    cycle(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    chk("conf_miss_dv", s_dv, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk("conf_biu_addr", s_baddr, 32'h1c000000);
    run_refill(D0);

    // Invalidate after preload
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    chk("inv_miss_dv", s_dv, 1'b0);
    run_refill(D0);

    // Invalidate during MISS_WAIT
    cycle(1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, D3);
    chk("invw_dv", s_dv, 1'b1);
    chk("invw_data", s_data, D3);
    cycle(1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    chk("invw_repeat_miss", s_dv, 1'b0);
    run_refill(D3);

    // Reset mid-refill
    cycle(1'b1, 32'h1c000018, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, D4);
    chk("rstm_dv", s_dv, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, D4);
    chk("rstm_late_dv", s_dv, 1'b0);
    chk("rstm_biu_req", s_breq, 1'b0);
    cycle(1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("rstm_ack", s_ack, 1'b1);
    idle();
    chk("rstm_miss_dv", s_dv, 1'b0);
    run_refill(D3);

    // Random traffic over a small address pool to force hits and conflicts
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = pool[$urandom_range(0, 2)] + ($urandom_range(0, 3) << 3) + $urandom_range(0, 7);
      cycle($urandom_range(0, 1) == 1, a, $urandom_range(0, 39) == 0,
            $urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
